// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding and
// the frame-timing defaults the receiver's frame counters also use.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  localparam int unsigned UART_BIT_CLKS  = 104;
  localparam int unsigned UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_tx_sync_fifo.sv
// Single-clock FIFO with level/full/empty. A push while full is accepted
// only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally at DEPTH (power of two); level alone decides full/empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1-style UART transmitter: bytes enter a FIFO via valid/ready and leave
// LSB-first on a registered, idle-high serial line.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned BIT_CLKS   = UART_BIT_CLKS,
  parameter int unsigned DATA_BITS  = UART_DATA_BITS,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          data_in,
  input  logic                          data_valid,
  output logic                          data_ready,
  output logic                          uart_tx_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned CW = $clog2(BIT_CLKS);
  localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  tx_state_e            state;
  tx_state_e            next_state;
  logic [CW-1:0]        cycle_cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shifter;
  logic [DATA_BITS-1:0] shifted;
  logic                 line_q;
  logic                 ready_en;
  logic                 bit_done;
  logic                 push;
  logic                 pop;
  logic [DATA_BITS-1:0] fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (data_in),
    .pop   (pop),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bit_done    = (cycle_cnt == '0);
  assign shifted     = shifter >> 1;
  assign uart_tx_out = line_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (!fifo_empty) next_state = START;
      START: if (bit_done) next_state = DATA;
      DATA:  if (bit_done && bit_cnt == '0) next_state = STOP;
      STOP:  if (bit_done && !stop_cnt) next_state = fifo_empty ? IDLE : START;
      default: next_state = IDLE;
    endcase
  end

  // A pop in the final stop cycle frees a slot, so a full FIFO can still accept that cycle.
  always_comb begin
    pop        = ((state == IDLE) && !fifo_empty) ||
                 ((state == STOP) && bit_done && !stop_cnt && !fifo_empty);
    data_ready = ready_en && (!fifo_full || pop);
    push       = data_valid && data_ready;
    busy       = (state != IDLE) || (fifo_level != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      shifter   <= '0;
      line_q    <= 1'b1;
      ready_en  <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      unique case (state)
        IDLE: begin
          if (pop) begin
            shifter   <= fifo_dout;
            line_q    <= 1'b0;
            cycle_cnt <= CW'(BIT_CLKS - 1);
          end
        end
        START: begin
          if (bit_done) begin
            line_q    <= shifter[0];
            bit_cnt   <= BW'(DATA_BITS - 1);
            cycle_cnt <= CW'(BIT_CLKS - 1);
          end else begin
            cycle_cnt <= cycle_cnt - CW'(1);
          end
        end
        DATA: begin
          if (bit_done) begin
            cycle_cnt <= CW'(BIT_CLKS - 1);
            if (bit_cnt != '0) begin
              shifter <= shifted;
              line_q  <= shifted[0];
              bit_cnt <= bit_cnt - BW'(1);
            end else begin
              line_q   <= 1'b1;
              stop_cnt <= 1'(STOP_BITS - 1);
            end
          end else begin
            cycle_cnt <= cycle_cnt - CW'(1);
          end
        end
        STOP: begin
          if (bit_done) begin
            cycle_cnt <= CW'(BIT_CLKS - 1);
            if (stop_cnt) begin
              stop_cnt <= 1'b0;
            end else if (pop) begin
              shifter <= fifo_dout;
              line_q  <= 1'b0;
            end
          end else begin
            cycle_cnt <= cycle_cnt - CW'(1);
          end
        end
        default: line_q <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: decodes the serial line cycle by cycle and
// checks framing, timing, FIFO handshake, reset and idle behaviour.
module tb_uart_tx;

  localparam int unsigned BIT_CLKS = 104;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       uart_tx_out;
  logic       busy;
  logic [2:0] fifo_level;

  int unsigned checks = 0;
  int unsigned passes = 0;

  uart_tx #(
    .BIT_CLKS   (BIT_CLKS),
    .DATA_BITS  (8),
    .STOP_BITS  (1),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .uart_tx_out (uart_tx_out),
    .busy        (busy),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Called at the first negedge where the start bit is visible; returns at
  // the negedge exactly one frame (10 bit times) later.
  task automatic check_frame(input string tag, input logic [7:0] b);
    logic exp;
    logic ok;
    for (int k = 0; k < 10; k++) begin
      exp = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      ok  = 1'b1;
      for (int c = 0; c < int'(BIT_CLKS); c++) begin
        if (uart_tx_out !== exp) ok = 1'b0;
        @(negedge clk);
      end
      chk($sformatf("%s_bit%0d", tag, k), ok, 1'b1);
    end
  endtask

  initial begin
    logic ok_line, ok_busy, ok_rdy, found;

    rst_n      = 1'b1;
    data_valid = 1'b0;
    data_in    = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_line",  uart_tx_out, 1'b1);
    chk("rst_ready", data_ready,  1'b0);
    chk("rst_busy",  busy,        1'b0);
    chk("rst_level", fifo_level,  3'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("ready_before_edge", data_ready, 1'b0);
    @(negedge clk);
    chk("ready_after_edge", data_ready, 1'b1);

    // Single byte 0xA5
    data_valid = 1'b1; data_in = 8'hA5;
    @(negedge clk);
    data_valid = 1'b0;
    chk("a5_line_e0",  uart_tx_out, 1'b1);
    chk("a5_level_e0", fifo_level,  3'd1);
    chk("a5_busy_e0",  busy,        1'b1);
    @(negedge clk);
    chk("a5_level_e1", fifo_level, 3'd0);
    check_frame("a5", 8'hA5);
    chk("a5_busy_end",  busy,        1'b0);
    chk("a5_line_end",  uart_tx_out, 1'b1);

    // Back-to-back 0x00, 0xFF
    data_valid = 1'b1; data_in = 8'h00;
    @(negedge clk);
    data_in = 8'hFF;
    @(negedge clk);
    data_valid = 1'b0;
    chk("b2b_level", fifo_level, 3'd1);
    check_frame("b2b_00", 8'h00);
    check_frame("b2b_ff", 8'hFF);
    chk("b2b_busy_end", busy, 1'b0);

    // Fill with 0x11..0x66 while holding data_valid
    data_valid = 1'b1; data_in = 8'h11;
    @(negedge clk);
    data_in = 8'h22;
    chk("fill_line_e0", uart_tx_out, 1'b1);
    @(negedge clk);
    fork
      check_frame("fill_11", 8'h11);
      begin
        data_in = 8'h33;
        @(negedge clk);
        data_in = 8'h44;
        @(negedge clk);
        data_in = 8'h55;
        @(negedge clk);
        data_in = 8'h66;
        chk("fill_full_ready", data_ready, 1'b0);
        chk("fill_full_level", fifo_level, 3'd4);
        found = 1'b0;
        for (int i = 0; i < 1100 && !found; i++) begin
          @(negedge clk);
          if (data_ready) found = 1'b1;
        end
        chk("fill_ready_returns", found, 1'b1);
        @(negedge clk);
        data_valid = 1'b0;
        chk("fill_level_swap", fifo_level, 3'd4);
      end
    join
    check_frame("fill_22", 8'h22);
    check_frame("fill_33", 8'h33);
    check_frame("fill_44", 8'h44);
    check_frame("fill_55", 8'h55);
    check_frame("fill_66", 8'h66);
    chk("fill_busy_end",  busy,       1'b0);
    chk("fill_level_end", fifo_level, 3'd0);

    // Reset during data bit 3 of 0xC3, with 0x99 still queued
    data_valid = 1'b1; data_in = 8'hC3;
    @(negedge clk);
    data_in = 8'h99;
    @(negedge clk);
    data_valid = 1'b0;
    chk("rmf_start", uart_tx_out, 1'b0);
    repeat (BIT_CLKS * 4 + 50) @(negedge clk);
    chk("rmf_bit3_low", uart_tx_out, 1'b0);
    chk("rmf_level",    fifo_level,  3'd1);
    rst_n = 1'b0;
    #1;
    chk("rmf_line",  uart_tx_out, 1'b1);
    chk("rmf_busy",  busy,        1'b0);
    chk("rmf_lvl0",  fifo_level,  3'd0);
    chk("rmf_ready", data_ready,  1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rmf_ready_back", data_ready, 1'b1);
    chk("rmf_idle_line",  uart_tx_out, 1'b1);
    data_valid = 1'b1; data_in = 8'h5A;
    @(negedge clk);
    data_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      @(negedge clk);
      if (uart_tx_out === 1'b0) found = 1'b1;
    end
    chk("rmf_5a_start_seen", found, 1'b1);
    check_frame("rmf_5a", 8'h5A);
    chk("rmf_busy_end", busy, 1'b0);

    // Idle integrity
    ok_line = 1'b1; ok_busy = 1'b1; ok_rdy = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (uart_tx_out !== 1'b1) ok_line = 1'b0;
      if (busy !== 1'b0)        ok_busy = 1'b0;
      if (data_ready !== 1'b1)  ok_rdy  = 1'b0;
    end
    chk("idle_line",  ok_line, 1'b1);
    chk("idle_busy",  ok_busy, 1'b1);
    chk("idle_ready", ok_rdy,  1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
